// File: rtl/gshare_predictor_if.sv
// Fetch-query, ROB-training and statistics bundle for the gshare predictor.
// master = fetcher/ROB side, slave = predictor.
interface gshare_predictor_if #(
   parameter int unsigned IDX_W = 7,
   parameter int unsigned GHR_W = 7
);
   logic [31:0]      input_ins;
   logic [31:0]      input_pc;
   logic             fetch_valid;
   logic [31:0]      predict_pc;
   logic             predict_taken;
   logic [IDX_W-1:0] predict_idx;
   logic [GHR_W-1:0] predict_ghr;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_idx;
   logic [GHR_W-1:0] upd_ghr;
   logic             upd_taken;
   logic             upd_mispredict;
   logic [31:0]      stat_branches;
   logic [31:0]      stat_mispredicts;

   modport master (
      output input_ins, input_pc, fetch_valid,
      output upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
      input  predict_pc, predict_taken, predict_idx, predict_ghr,
      input  stat_branches, stat_mispredicts
   );

   modport slave (
      input  input_ins, input_pc, fetch_valid,
      input  upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
      output predict_pc, predict_taken, predict_idx, predict_ghr,
      output stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: table of saturating counters indexed by PC ^ GHR,
// combinational next-PC prediction, speculative GHR with ROB recovery, commit statistics.
module gshare_predictor #(
   parameter int unsigned IDX_W    = 7,
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned GHR_W    = 7,
   parameter int unsigned CNT_INIT = 1
) (
   input logic               clk_in,
   input logic               rst_in,
   input logic               rdy_in,
   gshare_predictor_if.slave bus
);

   localparam int unsigned      Entries = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CntMax  = '1;

   logic [CNT_W-1:0] cnt_q [Entries];
   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [31:0]      branches_q, branches_d;
   logic [31:0]      mispredicts_q, mispredicts_d;

   logic             is_b, is_jal, taken;
   logic [31:0]      b_imm, j_imm;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] upd_cur, upd_next;

   // Prediction path
   always_comb begin
      is_b   = (bus.input_ins[6:0] == 7'b1100011);
      is_jal = (bus.input_ins[6:0] == 7'b1101111);
      b_imm  = {{20{bus.input_ins[31]}}, bus.input_ins[7], bus.input_ins[30:25],
                bus.input_ins[11:8], 1'b0};
      j_imm  = {{12{bus.input_ins[31]}}, bus.input_ins[19:12], bus.input_ins[20],
                bus.input_ins[30:21], 1'b0};
      idx    = bus.input_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
      taken  = is_jal | (is_b & cnt_q[idx][CNT_W-1]);

      bus.predict_pc = bus.input_pc + 32'd4;
      if (is_jal) begin
         bus.predict_pc = bus.input_pc + j_imm;
      end else if (is_b && taken) begin
         bus.predict_pc = bus.input_pc + b_imm;
      end
      bus.predict_taken    = taken;
      bus.predict_idx      = idx;
      bus.predict_ghr      = ghr_q;
      bus.stat_branches    = branches_q;
      bus.stat_mispredicts = mispredicts_q;
   end

   // Training and history next-state
   always_comb begin
      upd_cur  = cnt_q[bus.upd_idx];
      upd_next = upd_cur;
      if (bus.upd_taken) begin
         if (upd_cur != CntMax) upd_next = upd_cur + CNT_W'(1);
      end else if (upd_cur != '0) begin
         upd_next = upd_cur - CNT_W'(1);
      end

      // Shift form also covers GHR_W == 1; recovery wins over the speculative shift.
      ghr_d = ghr_q;
      if (bus.fetch_valid && is_b) begin
         ghr_d = (ghr_q << 1) | GHR_W'(taken);
      end
      if (bus.upd_valid && bus.upd_mispredict) begin
         ghr_d = (bus.upd_ghr << 1) | GHR_W'(bus.upd_taken);
      end

      branches_d    = branches_q;
      mispredicts_d = mispredicts_q;
      if (bus.upd_valid) begin
         if (branches_q != '1) branches_d = branches_q + 32'd1;
         if (bus.upd_mispredict && (mispredicts_q != '1)) begin
            mispredicts_d = mispredicts_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int unsigned i = 0; i < Entries; i++) begin
            cnt_q[i] <= CNT_W'(CNT_INIT);
         end
         ghr_q         <= '0;
         branches_q    <= '0;
         mispredicts_q <= '0;
      end else if (rdy_in) begin
         if (bus.upd_valid) begin
            cnt_q[bus.upd_idx] <= upd_next;
         end
         ghr_q         <= ghr_d;
         branches_q    <= branches_d;
         mispredicts_q <= mispredicts_d;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with hand-computed expectations.
module tb_gshare_predictor;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;

   int vectors     = 0;
   int miscompares = 0;

   gshare_predictor_if #(.IDX_W(7), .GHR_W(7)) bus ();

   gshare_predictor #(
      .IDX_W(7), .CNT_W(2), .GHR_W(7), .CNT_INIT(1)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .rdy_in(rdy_in),
      .bus   (bus)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] enc_b(input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_upd(input logic v, input logic [6:0] idx, input logic tk,
                          input logic mis, input logic [6:0] ghr);
      bus.upd_valid      = v;
      bus.upd_idx        = idx;
      bus.upd_taken      = tk;
      bus.upd_mispredict = mis;
      bus.upd_ghr        = ghr;
   endtask

   // One committed training update at idx 5 while querying a B at pc 0x14 (idx 5, ghr 0)
   task automatic train5(input logic tk, input logic exp_taken, input string tag);
      set_upd(1'b1, 7'd5, tk, 1'b0, 7'd0);
      tick();
      set_upd(1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
      #1;
      chk(tag, 32'(bus.predict_taken), 32'(exp_taken));
   endtask

   initial begin
      rst_in = 1'b1;
      rdy_in = 1'b1;
      bus.input_ins   = 32'd0;
      bus.input_pc    = 32'd0;
      bus.fetch_valid = 1'b0;
      set_upd(1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
      tick();
      tick();
      rst_in = 1'b0;
      #1;

      chk("rst_pc",    bus.predict_pc, 32'd4);
      chk("rst_taken", 32'(bus.predict_taken), 32'd0);
      chk("rst_idx",   32'(bus.predict_idx), 32'd0);
      chk("rst_ghr",   32'(bus.predict_ghr), 32'd0);
      chk("rst_br",    bus.stat_branches, 32'd0);
      chk("rst_mis",   bus.stat_mispredicts, 32'd0);

      bus.input_ins = enc_b(13'd16);
      bus.input_pc  = 32'h100;
      #1;
      chk("b_def_taken", 32'(bus.predict_taken), 32'd0);
      chk("b_def_pc",    bus.predict_pc, 32'h104);
      chk("b_def_idx",   32'(bus.predict_idx), 32'h40);

      bus.input_ins = enc_j(21'h1F_FFF8);
      #1;
      chk("jal_pc",    bus.predict_pc, 32'hF8);
      chk("jal_taken", 32'(bus.predict_taken), 32'd1);

      bus.input_ins = 32'h0000_0067;  // JALR: falls through
      #1;
      chk("jalr_pc", bus.predict_pc, 32'h104);

      // Saturation at idx 5: 1 -> 2 -> 3 -> 3 -> 3, down to 0, then back to 2
      bus.input_ins = enc_b(13'd8);
      bus.input_pc  = 32'h14;
      #1;
      chk("sat_init", 32'(bus.predict_taken), 32'd0);
      train5(1'b1, 1'b1, "sat_t1");
      chk("sat_t1_pc", bus.predict_pc, 32'h1C);
      train5(1'b1, 1'b1, "sat_t2");
      train5(1'b1, 1'b1, "sat_t3");
      train5(1'b1, 1'b1, "sat_t4");
      train5(1'b0, 1'b1, "sat_n1");
      train5(1'b0, 1'b0, "sat_n2");
      chk("sat_n2_pc", bus.predict_pc, 32'h18);
      train5(1'b0, 1'b0, "sat_n3");
      train5(1'b0, 1'b0, "sat_n4");
      train5(1'b0, 1'b0, "sat_n5");
      train5(1'b1, 1'b0, "sat_up1");
      train5(1'b1, 1'b1, "sat_up2");
      chk("sat_br",  bus.stat_branches, 32'd11);
      chk("sat_mis", bus.stat_mispredicts, 32'd0);

      // Speculative GHR: taken, taken, (JAL no shift), not-taken -> 3'b110
      bus.fetch_valid = 1'b1;
      #1;
      chk("ghr_q1_taken", 32'(bus.predict_taken), 32'd1);
      tick();
      chk("ghr_after1", 32'(bus.predict_ghr), 32'd1);
      bus.input_pc = 32'h10;
      #1;
      chk("ghr_q2_idx",   32'(bus.predict_idx), 32'd5);
      chk("ghr_q2_taken", 32'(bus.predict_taken), 32'd1);
      tick();
      bus.input_ins = enc_j(21'h1F_FFF8);
      bus.input_pc  = 32'h200;
      tick();
      chk("ghr_jal_noshift", 32'(bus.predict_ghr), 32'd3);
      bus.input_ins = enc_b(13'd8);
      bus.input_pc  = 32'h100;
      #1;
      chk("ghr_q3_idx",   32'(bus.predict_idx), 32'h43);
      chk("ghr_q3_taken", 32'(bus.predict_taken), 32'd0);
      tick();
      bus.fetch_valid = 1'b0;
      #1;
      chk("ghr_final", 32'(bus.predict_ghr), 32'h06);
      chk("ghr_idx",   32'(bus.predict_idx), 32'h46);

      // Recovery beats a same-cycle taken speculative shift
      bus.fetch_valid = 1'b1;
      bus.input_pc    = 32'h0C;
      set_upd(1'b1, 7'h7F, 1'b0, 1'b1, 7'h15);
      #1;
      chk("rec_spec_taken", 32'(bus.predict_taken), 32'd1);
      tick();
      bus.fetch_valid = 1'b0;
      set_upd(1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
      #1;
      chk("rec_ghr", 32'(bus.predict_ghr), 32'h2A);
      chk("rec_br",  bus.stat_branches, 32'd12);
      chk("rec_mis", bus.stat_mispredicts, 32'd1);

      // Stall: nothing moves, outputs still follow inputs
      rdy_in          = 1'b0;
      bus.fetch_valid = 1'b1;
      bus.input_pc    = 32'hBC;
      set_upd(1'b1, 7'd5, 1'b0, 1'b1, 7'h00);
      #1;
      chk("stall_taken", 32'(bus.predict_taken), 32'd1);
      chk("stall_pc",    bus.predict_pc, 32'hC4);
      tick();
      chk("stall_taken2", 32'(bus.predict_taken), 32'd1);
      chk("stall_ghr",    32'(bus.predict_ghr), 32'h2A);
      chk("stall_br",     bus.stat_branches, 32'd12);
      chk("stall_mis",    bus.stat_mispredicts, 32'd1);
      rdy_in          = 1'b1;
      bus.fetch_valid = 1'b0;

      // No bypass: same-cycle query sees the old counter
      set_upd(1'b1, 7'd5, 1'b0, 1'b0, 7'h00);
      #1;
      chk("nb_dec_old", 32'(bus.predict_taken), 32'd1);
      tick();
      set_upd(1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
      #1;
      chk("nb_dec_new", 32'(bus.predict_taken), 32'd0);
      set_upd(1'b1, 7'd5, 1'b1, 1'b0, 7'h00);
      #1;
      chk("nb_inc_old", 32'(bus.predict_taken), 32'd0);
      tick();
      set_upd(1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
      #1;
      chk("nb_inc_new", 32'(bus.predict_taken), 32'd1);
      chk("nb_br",      bus.stat_branches, 32'd14);

      // Reset overrides same-cycle update and fetch
      rst_in          = 1'b1;
      bus.fetch_valid = 1'b1;
      set_upd(1'b1, 7'd5, 1'b1, 1'b1, 7'h7F);
      tick();
      rst_in          = 1'b0;
      bus.fetch_valid = 1'b0;
      set_upd(1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
      bus.input_pc    = 32'h14;
      #1;
      chk("mr_ghr",   32'(bus.predict_ghr), 32'd0);
      chk("mr_br",    bus.stat_branches, 32'd0);
      chk("mr_mis",   bus.stat_mispredicts, 32'd0);
      chk("mr_idx",   32'(bus.predict_idx), 32'd5);
      chk("mr_taken", 32'(bus.predict_taken), 32'd0);
      chk("mr_pc",    bus.predict_pc, 32'h18);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
